// File: rtl/ball_motion_unit.sv
// Pong ball datapath and control: serves, per-frame motion, wall/paddle bounces and miss flags.
// Optional: define BALL_SPEEDUP_EN so each paddle hit raises the speed by one, up to MAX_SPEED.
module ball_motion_unit #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COORD_W    = 10,
  parameter int BALL_SIZE  = 8,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_X_L = 16,
  parameter int PADDLE_X_R = 616,
  parameter int SPEED      = 2,
  parameter int MAX_SPEED  = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               srv_l,
  input  logic               srv_r,
  input  logic               visible,
  input  logic [COORD_W-1:0] paddle_l_y,
  input  logic [COORD_W-1:0] paddle_r_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               ball_on,
  output logic               miss_l,
  output logic               miss_r
);

  localparam int EW = COORD_W + 2;

  localparam logic [COORD_W-1:0] X_HOME     = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_HOME     = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] FACE_L     = COORD_W'(PADDLE_X_L + PADDLE_W);
  localparam logic [COORD_W-1:0] FACE_R     = COORD_W'(PADDLE_X_R - BALL_SIZE);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(H_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(V_RES - BALL_SIZE);
  localparam logic [COORD_W-1:0] SERVE_OFS  = COORD_W'((PADDLE_H - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] SPEED_INIT = COORD_W'(SPEED);

  localparam logic [EW-1:0] FACE_L_E = EW'(PADDLE_X_L + PADDLE_W);
  localparam logic [EW-1:0] FACE_R_E = EW'(PADDLE_X_R - BALL_SIZE);
  localparam logic [EW-1:0] X_MAX_E  = EW'(H_RES - BALL_SIZE);
  localparam logic [EW-1:0] Y_MAX_E  = EW'(V_RES - BALL_SIZE);
  localparam logic [EW-1:0] BALL_E   = EW'(BALL_SIZE);
  localparam logic [EW-1:0] PH_E     = EW'(PADDLE_H);

  generate
    if (SPEED < 1 || MAX_SPEED < SPEED) begin : g_bad_cfg
      $error("ball_motion_unit: SPEED must be >= 1 and <= MAX_SPEED");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, MOVING, MISSED} state_t;

  state_t             state, state_nxt;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               dx, dy, dx_nxt, dy_nxt;
  logic               ml_nxt, mr_nxt;
  logic [COORD_W-1:0] speed;

`ifdef BALL_SPEEDUP_EN
  localparam logic [COORD_W-1:0] SPEED_MAX = COORD_W'(MAX_SPEED);
  logic [COORD_W-1:0] speed_nxt;
`else
  assign speed = SPEED_INIT;
`endif

  // Widened copies so every bound test is done without wrap-around
  logic [EW-1:0] bx_e, by_e, spd_e, pl_e, pr_e;
  logic          hit_l, hit_r;

  assign bx_e  = EW'(ball_x);
  assign by_e  = EW'(ball_y);
  assign spd_e = EW'(speed);
  assign pl_e  = EW'(paddle_l_y);
  assign pr_e  = EW'(paddle_r_y);

  assign hit_l = (bx_e >= FACE_L_E) && (bx_e <= FACE_L_E + spd_e) &&
                 (by_e + BALL_E > pl_e) && (by_e < pl_e + PH_E);
  assign hit_r = (bx_e <= FACE_R_E) && (bx_e + spd_e >= FACE_R_E) &&
                 (by_e + BALL_E > pr_e) && (by_e < pr_e + PH_E);

  always_comb begin
    state_nxt = state;
    x_nxt     = ball_x;
    y_nxt     = ball_y;
    dx_nxt    = dx;
    dy_nxt    = dy;
    ml_nxt    = miss_l;
    mr_nxt    = miss_r;
`ifdef BALL_SPEEDUP_EN
    speed_nxt = speed;
`endif
    case (state)
      IDLE, MISSED: begin
        if (srv_l || srv_r) begin
          state_nxt = MOVING;
          ml_nxt    = 1'b0;
          mr_nxt    = 1'b0;
          dy_nxt    = 1'b0;
`ifdef BALL_SPEEDUP_EN
          speed_nxt = SPEED_INIT;
`endif
          if (srv_l) begin
            x_nxt  = FACE_L;
            y_nxt  = paddle_l_y + SERVE_OFS;
            dx_nxt = 1'b1;
          end else begin
            x_nxt  = FACE_R;
            y_nxt  = paddle_r_y + SERVE_OFS;
            dx_nxt = 1'b0;
          end
        end
      end
      MOVING: begin
        if (frame_tick) begin
          if (!dy) begin
            if (by_e < spd_e) begin
              y_nxt  = '0;
              dy_nxt = 1'b1;
            end else begin
              y_nxt = ball_y - speed;
            end
          end else if (by_e + spd_e >= Y_MAX_E) begin
            y_nxt  = Y_MAX;
            dy_nxt = 1'b0;
          end else begin
            y_nxt = ball_y + speed;
          end

          // dx=1 means travelling right
          if (!dx) begin
            if (hit_l) begin
              x_nxt  = FACE_L;
              dx_nxt = 1'b1;
            end else if (bx_e < spd_e) begin
              x_nxt     = '0;
              ml_nxt    = 1'b1;
              state_nxt = MISSED;
            end else begin
              x_nxt = ball_x - speed;
            end
          end else if (hit_r) begin
            x_nxt  = FACE_R;
            dx_nxt = 1'b0;
          end else if (bx_e + spd_e > X_MAX_E) begin
            x_nxt     = X_MAX;
            mr_nxt    = 1'b1;
            state_nxt = MISSED;
          end else begin
            x_nxt = ball_x + speed;
          end

`ifdef BALL_SPEEDUP_EN
          if (((!dx && hit_l) || (dx && hit_r)) && speed < SPEED_MAX)
            speed_nxt = speed + 1'b1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ball_x  <= X_HOME;
      ball_y  <= Y_HOME;
      dx      <= 1'b1;
      dy      <= 1'b0;
      miss_l  <= 1'b0;
      miss_r  <= 1'b0;
      ball_on <= 1'b0;
    end else begin
      state   <= state_nxt;
      ball_x  <= x_nxt;
      ball_y  <= y_nxt;
      dx      <= dx_nxt;
      dy      <= dy_nxt;
      miss_l  <= ml_nxt;
      miss_r  <= mr_nxt;
      ball_on <= visible;
    end
  end

`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge clk) begin
    if (reset) speed <= SPEED_INIT;
    else       speed <= speed_nxt;
  end
`endif

endmodule

// File: tb/tb_ball_motion_unit.sv
// Self-checking bench for ball_motion_unit: directed literal scenarios, then randomized play
// compared every cycle against a behavioural model of the ball.
module tb_ball_motion_unit;

  localparam int H_RES = 640, V_RES = 480, BALL_SIZE = 8, PADDLE_W = 8, PADDLE_H = 64;
  localparam int PADDLE_X_L = 16, PADDLE_X_R = 616, SPEED = 2, MAX_SPEED = 6;
  localparam int FACE_L = PADDLE_X_L + PADDLE_W;
  localparam int FACE_R = PADDLE_X_R - BALL_SIZE;
  localparam int X_MAX  = H_RES - BALL_SIZE;
  localparam int Y_MAX  = V_RES - BALL_SIZE;
`ifdef BALL_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam int HIT_SPD = SPEEDUP ? SPEED + 1 : SPEED;

  logic       clk = 1'b0;
  logic       reset = 1'b1, frame_tick = 1'b0, srv_l = 1'b0, srv_r = 1'b0, visible = 1'b0;
  logic [9:0] paddle_l_y = '0, paddle_r_y = '0;
  logic [9:0] ball_x, ball_y;
  logic       ball_on, miss_l, miss_r;

  int compared = 0;
  int mismatched = 0;
  bit check_en = 1'b0;

  typedef struct {
    int x; int y; bit right; bit down; bit moving; bit ml; bit mr; bit on; int spd;
  } model_t;
  model_t m;

  ball_motion_unit dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .srv_l(srv_l), .srv_r(srv_r),
    .visible(visible), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y), .ball_on(ball_on), .miss_l(miss_l), .miss_r(miss_r)
  );

  always #5 clk = ~clk;

  function automatic bit overlaps(int by, int py);
    return (by + BALL_SIZE > py) && (by < py + PADDLE_H);
  endfunction

  // One clock edge of the ball as described by the game rules
  function automatic model_t modelNext(model_t c, bit rst, bit ft, bit sl, bit sr, bit vis,
                                       int pl, int pr);
    model_t n = c;
    bit hit = 1'b0;
    n.on = vis;
    if (rst) begin
      n = '{x: X_MAX / 2, y: Y_MAX / 2, right: 1'b1, down: 1'b0, moving: 1'b0,
            ml: 1'b0, mr: 1'b0, on: 1'b0, spd: SPEED};
    end else if (!c.moving) begin
      if (sl || sr) begin
        n.moving = 1'b1; n.ml = 1'b0; n.mr = 1'b0; n.down = 1'b0; n.spd = SPEED;
        n.right  = sl;
        n.x      = sl ? FACE_L : FACE_R;
        n.y      = ((sl ? pl : pr) + (PADDLE_H - BALL_SIZE) / 2) % 1024;
      end
    end else if (ft) begin
      if (!c.down) begin
        if (c.y - c.spd < 0) begin n.y = 0; n.down = 1'b1; end
        else n.y = c.y - c.spd;
      end else begin
        if (c.y + c.spd >= Y_MAX) begin n.y = Y_MAX; n.down = 1'b0; end
        else n.y = c.y + c.spd;
      end
      if (!c.right) begin
        if (c.x >= FACE_L && c.x - c.spd <= FACE_L && overlaps(c.y, pl)) begin
          n.x = FACE_L; n.right = 1'b1; hit = 1'b1;
        end else if (c.x - c.spd < 0) begin
          n.x = 0; n.ml = 1'b1; n.moving = 1'b0;
        end else n.x = c.x - c.spd;
      end else begin
        if (c.x <= FACE_R && c.x + c.spd >= FACE_R && overlaps(c.y, pr)) begin
          n.x = FACE_R; n.right = 1'b0; hit = 1'b1;
        end else if (c.x + c.spd > X_MAX) begin
          n.x = X_MAX; n.mr = 1'b1; n.moving = 1'b0;
        end else n.x = c.x + c.spd;
      end
      if (SPEEDUP && hit && c.spd < MAX_SPEED) n.spd = c.spd + 1;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit ft, input bit sl, input bit sr, input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = ft; srv_l = sl; srv_r = sr;
      @(posedge clk);
      @(negedge clk);
    end
    srv_l = 1'b0; srv_r = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    reset = 1'b0;
  endtask

  task automatic waitMissR(input string name);
    for (int i = 0; i < 400 && !miss_r; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput(name, int'(miss_r), 1);
  endtask

  initial forever begin
    @(posedge clk);
    m = modelNext(m, reset, frame_tick, srv_l, srv_r, visible, int'(paddle_l_y), int'(paddle_r_y));
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      checkOutput("model_ball_x", int'(ball_x), m.x);
      checkOutput("model_ball_y", int'(ball_y), m.y);
      checkOutput("model_ball_on", int'(ball_on), int'(m.on));
      checkOutput("model_miss_l", int'(miss_l), int'(m.ml));
      checkOutput("model_miss_r", int'(miss_r), int'(m.mr));
    end
  end

  initial begin
    visible = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    check_en = 1'b1;
    checkOutput("reset_x", int'(ball_x), 316);
    checkOutput("reset_y", int'(ball_y), 236);
    checkOutput("reset_miss_l", int'(miss_l), 0);
    checkOutput("reset_miss_r", int'(miss_r), 0);
    checkOutput("reset_ball_on", int'(ball_on), 0);

    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("idle_tick_x", int'(ball_x), 316);
    checkOutput("idle_tick_y", int'(ball_y), 236);
    checkOutput("ball_on_follow", int'(ball_on), 1);

    paddle_l_y = 10'd100;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("serve_l_x", int'(ball_x), 24);
    checkOutput("serve_l_y", int'(ball_y), 128);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("first_tick_x", int'(ball_x), 26);
    checkOutput("first_tick_y", int'(ball_y), 126);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("srv_in_moving_x", int'(ball_x), 26);
    checkOutput("srv_in_moving_y", int'(ball_y), 126);

    pulseReset();
    checkOutput("mid_reset_x", int'(ball_x), 316);
    checkOutput("mid_reset_y", int'(ball_y), 236);

    paddle_l_y = 10'd1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 14);
    checkOutput("top_approach_y", int'(ball_y), 1);
    checkOutput("top_approach_x", int'(ball_x), 52);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("top_clamp_y", int'(ball_y), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("top_bounce_y", int'(ball_y), 2);

    pulseReset();
    paddle_l_y = 10'd350; paddle_r_y = 10'd0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("serve_r_x", int'(ball_x), 608);
    checkOutput("serve_r_y", int'(ball_y), 28);
    applyStimulus(1'b1, 1'b0, 1'b0, 292);
    checkOutput("left_hit_x", int'(ball_x), 24);
    checkOutput("left_hit_y", int'(ball_y), 390);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("after_hit_x", int'(ball_x), 24 + HIT_SPD);
    checkOutput("after_hit_y", int'(ball_y), 390 - HIT_SPD);

    pulseReset();
    paddle_l_y = 10'd100; paddle_r_y = 10'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    waitMissR("miss_r_wait");
    checkOutput("miss_r_x", int'(ball_x), 632);
    checkOutput("miss_r_miss_l", int'(miss_l), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("miss_r_hold", int'(miss_r), 1);
    checkOutput("miss_r_hold_x", int'(ball_x), 632);
    paddle_r_y = 10'd400;
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("reserve_miss_r", int'(miss_r), 0);
    checkOutput("reserve_x", int'(ball_x), 608);
    checkOutput("reserve_y", int'(ball_y), 428);

    pulseReset();
    paddle_l_y = 10'd100; paddle_r_y = 10'd0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    waitMissR("miss_r_wait2");
    paddle_l_y = 10'd200; paddle_r_y = 10'd300;
    applyStimulus(1'b0, 1'b1, 1'b1, 1);
    checkOutput("both_srv_x", int'(ball_x), 24);
    checkOutput("both_srv_y", int'(ball_y), 228);
    checkOutput("both_srv_miss_r", int'(miss_r), 0);

    // Paddles mostly shadow the ball so hits are frequent; occasional random jumps give misses
    for (int i = 0; i < 15000; i++) begin
      int t;
      reset   = ($urandom_range(0, 999) == 0);
      visible = ($urandom_range(0, 3) != 0);
      t = ($urandom_range(0, 9) < 7) ? m.y - int'($urandom_range(0, 60)) : int'($urandom_range(0, 416));
      paddle_l_y = 10'(t < 0 ? 0 : (t > 416 ? 416 : t));
      t = ($urandom_range(0, 9) < 7) ? m.y - int'($urandom_range(0, 60)) : int'($urandom_range(0, 416));
      paddle_r_y = 10'(t < 0 ? 0 : (t > 416 ? 416 : t));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                    $urandom_range(0, 40) == 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
